// File: rtl/run_controller.sv
// Test-run controller: sequences CPU reset, bounds the run by a cycle budget,
// waits for the post-halt cache drain and reports counters plus a final status.
module run_controller #(
  parameter int         RESET_CYCLES  = 2,
  parameter int         MAX_CYCLES    = 500,
  parameter int         DRAIN_TIMEOUT = 64,
  parameter int         NUM_EVENTS    = 4,
  parameter int         CNT_W         = 64,
  parameter logic [6:0] HALT_OPCODE   = 7'h7f
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        wb_valid,
  input  logic [31:0]                 wb_instr,
  input  logic                        drain_done,
  input  logic [NUM_EVENTS-1:0]       event_in,
  output logic                        core_reset,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  status,
  output logic [CNT_W-1:0]            cycle_count,
  output logic [CNT_W-1:0]            retired_count,
  output logic [NUM_EVENTS*CNT_W-1:0] event_count
);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [1:0] ST_NONE     = 2'd0;
  localparam logic [1:0] ST_HALTED   = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;
  localparam logic [1:0] ST_DRAIN_TO = 2'd3;

  localparam int HOLD_W  = (RESET_CYCLES  < 2) ? 1 : $clog2(RESET_CYCLES);
  localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LIM = DRAIN_W'(DRAIN_TIMEOUT);
  localparam logic [CNT_W-1:0]   MAX_C     = CNT_W'(MAX_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e             state_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic [CNT_W-1:0]   cycle_q;
  logic [CNT_W-1:0]   retired_q;
  logic [1:0]         status_q;
  logic               core_reset_q;
  logic               busy_q;
  logic               done_q;

  logic [CNT_W-1:0]   cycle_d;
  logic [DRAIN_W-1:0] drain_cnt_d;
  logic               halt_seen;
  logic               start_ok;
  logic               counting;

  assign cycle_d     = sat_inc(cycle_q);
  assign drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
  assign halt_seen   = wb_valid && (wb_instr[6:0] == HALT_OPCODE);
  assign start_ok    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign counting    = (state_q == S_RUN) || (state_q == S_DRAIN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      hold_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      cycle_q      <= '0;
      retired_q    <= '0;
      status_q     <= ST_NONE;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            state_q      <= S_HOLD;
            hold_cnt_q   <= '0;
            cycle_q      <= '0;
            retired_q    <= '0;
            status_q     <= ST_NONE;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q      <= S_RUN;
            core_reset_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        S_RUN: begin
          cycle_q <= cycle_d;
          if (wb_valid) retired_q <= sat_inc(retired_q);
          // A halt on the budget's last cycle still drains rather than timing out.
          if (halt_seen) begin
            state_q     <= S_DRAIN;
            drain_cnt_q <= '0;
          end else if (cycle_d == MAX_C) begin
            state_q  <= S_DONE;
            status_q <= ST_TIMEOUT;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        S_DRAIN: begin
          cycle_q     <= cycle_d;
          drain_cnt_q <= drain_cnt_d;
          if (drain_done || (drain_cnt_d == DRAIN_LIM)) begin
            state_q  <= S_DONE;
            status_q <= drain_done ? ST_HALTED : ST_DRAIN_TO;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_evt
      logic [CNT_W-1:0] evt_q;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          evt_q <= '0;
        end else if (start_ok) begin
          evt_q <= '0;
        end else if (counting && event_in[gi]) begin
          evt_q <= sat_inc(evt_q);
        end
      end
      assign event_count[gi*CNT_W +: CNT_W] = evt_q;
    end
  endgenerate

  assign core_reset    = core_reset_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign status        = status_q;
  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_run_controller.sv
// Randomized scoreboard bench for run_controller: a run-level reference model
// predicts each run's outcome and a monitor checks it when done rises.
module tb_run_controller;
  localparam int RC  = 2;
  localparam int MAX = 500;
  localparam int DT  = 64;
  localparam int NE  = 4;
  localparam int TOT = MAX + DT;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          wb_valid = 1'b0;
  logic [31:0]   wb_instr = '0;
  logic          drain_done = 1'b0;
  logic [NE-1:0] event_in = '0;
  logic          core_reset, busy, done;
  logic [1:0]    status;
  logic [63:0]   cycle_count, retired_count;
  logic [NE*64-1:0] event_count;

  run_controller #(.RESET_CYCLES(RC), .MAX_CYCLES(MAX), .DRAIN_TIMEOUT(DT),
                   .NUM_EVENTS(NE), .CNT_W(64), .HALT_OPCODE(7'h7f)) dut (
    .clock(clock), .reset(reset), .start(start), .wb_valid(wb_valid),
    .wb_instr(wb_instr), .drain_done(drain_done), .event_in(event_in),
    .core_reset(core_reset), .busy(busy), .done(done), .status(status),
    .cycle_count(cycle_count), .retired_count(retired_count),
    .event_count(event_count));

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]       st;
    logic [63:0]      cyc;
    logic [63:0]      ret;
    logic [NE*64-1:0] ev;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  bit          v_arr [1:TOT];
  logic [31:0] i_arr [1:TOT];
  bit          d_arr [1:TOT];
  logic [NE-1:0] e_arr [1:TOT];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " core_reset"}, core_reset, 1);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " status"}, status, 0);
    check({tag, " cycle_count"}, cycle_count, 0);
    check({tag, " retired_count"}, retired_count, 0);
    check({tag, " event_count"}, (event_count == '0) ? 64'd1 : 64'd0, 1);
  endtask

  // Run-level model: locate the halt and the drain completion, then count.
  function automatic exp_t model(output int n_total);
    exp_t e;
    int k = 0, d = 0;
    e.ret = 0; e.ev = '0;
    for (int n = 1; n <= MAX; n++)
      if (v_arr[n] && i_arr[n][6:0] == 7'h7f) begin k = n; break; end
    if (k == 0) begin
      e.st = 2'd2; n_total = MAX;
      for (int n = 1; n <= MAX; n++) e.ret += 64'(v_arr[n]);
    end else begin
      for (int n = 1; n <= k; n++) e.ret += 64'(v_arr[n]);
      for (int j = 1; j <= DT; j++)
        if (d_arr[k + j]) begin d = j; break; end
      if (d != 0) begin e.st = 2'd1; n_total = k + d; end
      else begin e.st = 2'd3; n_total = k + DT; end
    end
    e.cyc = 64'(n_total);
    for (int c = 0; c < NE; c++) begin
      logic [63:0] cnt = 0;
      for (int n = 1; n <= n_total; n++) cnt += 64'(e_arr[n][c]);
      e.ev[c*64 +: 64] = cnt;
    end
    return e;
  endfunction

  task automatic run_test(input int halt_at, input int drain_at, input bit nop_only,
                          input bit ev_fixed, input int start_at);
    exp_t e;
    int   n_total;
    logic [31:0] tmp;
    for (int n = 1; n <= TOT; n++) begin
      v_arr[n] = nop_only ? 1'b1 : ($urandom_range(0, 3) != 0);
      tmp = nop_only ? 32'h0000_0013 : $urandom;
      if (tmp[6:0] == 7'h7f) tmp[6:0] = 7'h33;
      i_arr[n] = tmp;
      d_arr[n] = nop_only ? 1'b0 : ($urandom_range(0, 15) == 0);
      e_arr[n] = ev_fixed ? 4'b0101 : NE'($urandom);
    end
    if (halt_at > 0) begin
      tmp = nop_only ? 32'h0000_007f : $urandom;
      tmp[6:0] = 7'h7f;
      v_arr[halt_at] = 1'b1;
      i_arr[halt_at] = tmp;
      if (drain_at > 0 && halt_at + drain_at <= TOT) d_arr[halt_at + drain_at] = 1'b1;
    end
    e = model(n_total);
    exp_q.push_back(e);

    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    for (int j = 0; j < RC; j++) begin
      check("hold core_reset", core_reset, 1);
      check("hold busy", busy, 1);
      @(negedge clock);
    end
    for (int n = 1; n <= n_total; n++) begin
      if (n == 1) check("run core_reset", core_reset, 0);
      check("done early", done, 0);
      check("busy in run", busy, 1);
      wb_valid   = v_arr[n];
      wb_instr   = i_arr[n];
      drain_done = d_arr[n];
      event_in   = e_arr[n];
      start      = (n == start_at);
      @(negedge clock);
    end
    wb_valid = 0; wb_instr = '0; drain_done = 0; event_in = '0; start = 0;
    check("done rise", done, 1);
    check("busy after", busy, 0);
    check("core_reset after", core_reset, 0);
    repeat (3) @(negedge clock);
    check("done held", done, 1);
  endtask

  // Monitor: compare each completed run against the oldest prediction.
  initial begin
    logic done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("status", status, e.st);
          check("cycle_count", cycle_count, e.cyc);
          check("retired_count", retired_count, e.ret);
          for (int c = 0; c < NE; c++)
            check($sformatf("event_count[%0d]", c), event_count[c*64 +: 64], e.ev[c*64 +: 64]);
          $display("run done: status=%0d cycles=%0d retired=%0d", status, cycle_count, retired_count);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check_idle("in reset");
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_idle("idle");
    end

    run_test(11, 3, 1'b1, 1'b0, 0);     // halt at 11, drain on 3rd cycle
    run_test(0, 0, 1'b1, 1'b0, 0);      // NOPs only: budget expiry
    run_test(5, 0, 1'b1, 1'b0, 0);      // drain never completes
    run_test(MAX, 10, 1'b1, 1'b1, 0);   // halt on the last budget cycle
    run_test(37, 20, 1'b0, 1'b0, 7);    // mid-run start is ignored
    for (int r = 0; r < 3; r++)
      run_test(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, MAX)),
               int'($urandom_range(1, 80)), 1'b0, 1'b0, int'($urandom_range(1, 40)));

    // Asynchronous reset in RUN cycle 20 with a start pulse in flight.
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (RC) @(negedge clock);
    for (int n = 1; n < 20; n++) begin
      wb_valid = 1'b1; wb_instr = 32'h13; event_in = 4'b1111;
      start = (n == 10);
      @(negedge clock);
    end
    start = 1'b0;
    check("pre-reset busy", busy, 1);
    #2 reset = 1'b0;
    #1 check_idle("async reset");
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    wb_valid = 1'b0; wb_instr = '0; event_in = '0;
    check_idle("held reset");
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check_idle("after reset");
    end
    check("pending runs", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/run_controller.md
# run_controller

Synthesizable test-run controller placed between the simulation bench and `RISCVCPU`. It sequences the CPU's reset and bounds the run with a cycle limit. It detects the drain/halt instruction (opcode 7'h7f) retiring at writeback and waits for the cache drain to complete. It also exposes cycle, retire and per-channel event counters plus a final run status, so benches check completion instead of running a fixed cycle count.

## Interface
Parameters:
- RESET_CYCLES, 2: cycles `core_reset` is held high after `start`; must be ≥1.
- MAX_CYCLES, 500: cycle budget for RUN state.
- DRAIN_TIMEOUT, 64: cycle budget for DRAIN state.
- NUM_EVENTS, 4: number of event-counter channels.
- CNT_W, 64: width of every counter.
- HALT_OPCODE, 7'h7f: opcode field (`wb_instr[6:0]`) that ends the run.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; asserts immediately, releases synchronously to `clock`.
- start  in  1  run request pulse; honoured only in IDLE or DONE.
- wb_valid  in  1  an instruction retires this cycle.
- wb_instr  in  32  retiring instruction word.
- drain_done  in  1  cache-to-DMEM drain complete.
- event_in  in  NUM_EVENTS  per-channel event strobes (stall, flush, miss, ...).
- core_reset  out  1  active-high reset to the CPU.
- busy  out  1  high in RESET_HOLD, RUN and DRAIN.
- done  out  1  high in DONE.
- status  out  2  0 NONE, 1 HALTED, 2 TIMEOUT, 3 DRAIN_TIMEOUT.
- cycle_count  out  CNT_W  cycles spent in RUN plus DRAIN.
- retired_count  out  CNT_W  `wb_valid` cycles counted in RUN.
- event_count  out  NUM_EVENTS*CNT_W  channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- States: IDLE, RESET_HOLD, RUN, DRAIN, DONE.
- Reset values: state IDLE, `core_reset`=1, `busy`=0, `done`=0, `status`=0, all counters 0.
- IDLE:
  - `core_reset`=1.
  - `start` clears all counters and `status`, then goes to RESET_HOLD.
- RESET_HOLD:
  - `core_reset`=1 for exactly RESET_CYCLES cycles, then goes to RUN.
- RUN:
  - `core_reset`=0.
  - `cycle_count` increments every cycle.
  - `retired_count` increments on each `wb_valid`.
  - `wb_valid` && `wb_instr[6:0]`==HALT_OPCODE goes to DRAIN; the halt instruction is counted as retired.
  - If the incremented `cycle_count` equals MAX_CYCLES and no halt is seen, go to DONE with `status`=2.
- DRAIN:
  - `cycle_count` keeps incrementing; `retired_count` is frozen.
  - An internal drain timer counts DRAIN cycles.
  - `drain_done` goes to DONE with `status`=1.
  - Timer reaching DRAIN_TIMEOUT goes to DONE with `status`=3.
- DONE:
  - `core_reset`=0, so CPU state is preserved for inspection.
  - All counters and `status` are frozen.
  - `start` restarts from RESET_HOLD and clears counters.
- Event counters increment in RUN and DRAIN when their `event_in` bit is high.
- All counters saturate at all-ones; they never wrap.
- Simultaneous events:
  - Halt on the same cycle the budget expires: halt wins, go to DRAIN.
  - `drain_done` on the same cycle the drain timer expires: `status`=1.
  - `start` in RESET_HOLD, RUN or DRAIN is ignored.
- Reset asserted mid-run: everything returns to reset values immediately, with no completion reported.

## Timing
- All outputs are registered.
- `start` high at edge t:
  - RESET_HOLD from t+1.
  - `core_reset` high for edges t+1 … t+RESET_CYCLES.
  - RUN from t+RESET_CYCLES+1.
- The cycle a state is entered counts toward that state's counters.
- Halt seen at RUN cycle k: `retired_count` includes it, `cycle_count`=k, DRAIN begins the next cycle.
- `drain_done` on DRAIN cycle d: that cycle is counted, so final `cycle_count`=k+d; `done` rises the following cycle.
- Timeout: after exactly MAX_CYCLES RUN cycles, `cycle_count`=MAX_CYCLES and `done` rises the next cycle.

## Test plan
- Reset low, then release: `core_reset`=1, `busy`=0, `done`=0, `status`=0, all counts 0, for 5 idle cycles.
- `start`, NOP retired every RUN cycle, 0x0000007f retired on RUN cycle 11, `drain_done` on the 3rd DRAIN cycle -> `status`=1, `retired_count`=11, `cycle_count`=14, `done`=1, `core_reset` held high for exactly 2 cycles.
- `start`, NOPs only -> `status`=2, `cycle_count`=500, `done` one cycle after the 500th RUN cycle.
- Halt on RUN cycle 5, `drain_done` never asserted -> `status`=3, `cycle_count`=69.
- Halt retires on RUN cycle 500 -> DRAIN entered, not TIMEOUT; `event_in`=4'b0101 held throughout -> channels 0 and 2 equal `cycle_count`, channels 1 and 3 equal 0.
- `reset` low in RUN cycle 20, then `start` re-pulsed during RUN -> all outputs at reset values immediately; the mid-RUN `start` is ignored.
